// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between single-cycle writeback (A) and a FIFO-buffered multi-cycle unit (B)
// Ports: clk, reset (async, active-high)
//   A:      a_valid, a_rd, a_data in; a_stall out (upstream holds A while high)
//   B:      b_valid, b_rd, b_data in; b_ready out (FIFO not full)
//   decode: issue_valid/issue_rd set pending bits; rs1/rs2 in, rs1_pending/rs2_pending out
//   rf:     rf_we, rf_rd, rf_wd drive the register file write port
// Macro REGFILE_WB_ARB_STARVE_EN builds the starvation guard (wait_cnt, a_stall); without it A has strict priority.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_stall,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_pending,
    output logic              rs2_pending,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wd
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NR = 1 << ADDR_W;
    logic [ADDR_W-1:0] q_rd [FIFO_DEPTH];
    logic [DATA_W-1:0] q_wd [FIFO_DEPTH];
    logic [PW:0]       wp, rp;
    logic [NR-1:0]     pend, pend_n;
    logic              full, empty, push, a_go, a_gnt, h_gnt;

    assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign empty   = wp == rp;
    assign b_ready = !reset && !full;
    // x0 results are accepted but never buffered
    assign push    = b_valid && b_ready && b_rd != '0;
    assign a_go    = !reset && a_valid && a_rd != '0;
    // a_stall hands the port to the FIFO head regardless of A
    assign h_gnt   = !reset && !empty && (a_stall || !a_go);
    assign a_gnt   = a_go && !h_gnt;
    assign rf_we   = a_gnt || h_gnt;
    assign rf_rd   = a_gnt ? a_rd : h_gnt ? q_rd[rp[PW-1:0]] : '0;
    assign rf_wd   = a_gnt ? a_data : h_gnt ? q_wd[rp[PW-1:0]] : '0;
    assign rs1_pending = pend[rs1];
    assign rs2_pending = pend[rs2];

    // clear first so a same-cycle issue to the same register wins
    always_comb begin
        pend_n = pend;
        if (h_gnt) pend_n[rf_rd] = 1'b0;
        if (issue_valid) pend_n[issue_rd] = 1'b1;
        pend_n[0] = 1'b0;
    end

    always_ff @(posedge clk)
        if (push) begin
            q_rd[wp[PW-1:0]] <= b_rd;
            q_wd[wp[PW-1:0]] <= b_data;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp   <= '0;
            rp   <= '0;
            pend <= '0;
        end else begin
            wp   <= wp + (PW+1)'(push);
            rp   <= rp + (PW+1)'(h_gnt);
            pend <= pend_n;
        end

`ifdef REGFILE_WB_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
    logic [CW-1:0] wait_cnt;

    // a_stall is a one-cycle pulse: its own cycle always grants the head, which clears it
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wait_cnt <= '0;
            a_stall  <= 1'b0;
        end else begin
            wait_cnt <= (empty || h_gnt) ? '0 : (wait_cnt == LIM) ? LIM : wait_cnt + 1'b1;
            a_stall  <= !empty && !h_gnt && wait_cnt == LIM - 1'b1;
        end
`else
    assign a_stall = 1'b0;
`endif
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32×32 register file. It shares the file's single write port between two sources: the single-cycle writeback path, which has fixed priority, and a multi-cycle unit such as a divider or load unit. The multi-cycle unit's results are buffered in a small FIFO. The block also tracks destination registers with outstanding multi-cycle results so that decode can stall dependent instructions.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- FIFO_DEPTH, 4, multi-cycle result buffer entries; power of 2, ≥2
- STARVE_LIMIT, 8, cycles a buffered result may wait before the guard fires; ≥2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- a_valid  in  1  single-cycle writeback request; no ready signal, always accepted unless a_stall=1
- a_rd  in  ADDR_W  destination register for port A
- a_data  in  DATA_W  write data for port A
- a_stall  out  1  registered; upstream must hold its A request while this is high
- b_valid  in  1  multi-cycle result valid
- b_ready  out  1  FIFO not full
- b_rd  in  ADDR_W  destination register for port B
- b_data  in  DATA_W  write data for port B
- issue_valid  in  1  a multi-cycle op is issued this cycle
- issue_rd  in  ADDR_W  destination register of the issued op
- rs1, rs2  in  ADDR_W  source registers being decoded
- rs1_pending, rs2_pending  out  1  combinational lookup of the pending bits
- rf_we  out  1  register file write enable
- rf_rd  out  ADDR_W  register file write address
- rf_wd  out  DATA_W  register file write data

## Operation
- **B port and FIFO**
  - B handshake: a transfer occurs when b_valid && b_ready.
  - b_ready = !full, with no pass-through when full.
  - A transfer with b_rd=0 is accepted and discarded, not enqueued.
- **Grant, evaluated each cycle**
  - If a_stall=1 and the FIFO is non-empty: the FIFO head is granted and popped. a_valid is ignored that cycle.
  - Else if a_valid && a_rd≠0: A is granted.
  - Else if the FIFO is non-empty: the FIFO head is granted and popped.
  - Otherwise: rf_we=0.
  - a_valid with a_rd=0 never asserts rf_we and does not block the FIFO.
- **Write port outputs**
  - rf_we/rf_rd/rf_wd are combinational from the grant.
  - rf_rd and rf_wd are 0 when rf_we=0.
- **Scoreboard**: 32 pending bits; bit 0 is hard-wired to 0.
  - issue_valid with issue_rd≠0 sets pending[issue_rd].
  - A FIFO-head write clears pending[rf_rd].
  - If a set and a clear hit the same index in the same cycle, the set wins.
- **Starvation counter wait_cnt** (ceil(log2(STARVE_LIMIT+1)) bits)
  - Increments each cycle the FIFO is non-empty and its head is not granted.
  - Clears on any head grant, and when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- **a_stall**
  - Set at the next edge when wait_cnt==STARVE_LIMIT-1 and the head is not granted.
  - Cleared at the edge after it causes a head grant.
- **FIFO**
  - Read and write pointers are each log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH.
  - full = MSBs differ and the lower bits are equal. empty = pointers equal.
  - Push and pop in the same cycle are legal when not full; the count is unchanged.

## Timing
- **Reset**
  - Asynchronous; clears the FIFO pointers, all pending bits, wait_cnt and a_stall.
  - During reset: b_ready=0, rf_we=0, rf_rd=0, rf_wd=0.
  - b_ready rises on the first cycle after reset deasserts.
  - Reset asserted mid-operation discards buffered results and pending bits.
- **Latency**
  - Port A to rf_we: 0 cycles, same cycle.
  - Port B to rf_we: ≥1 cycle. With the FIFO empty and a_valid=0, the write occurs in the cycle after the B transfer.
- **Guard timing**
  - a_stall rises STARVE_LIMIT cycles after the head's first ungranted cycle.
  - a_stall is high for exactly 1 cycle per guard event.
- **Read path**: rs*_pending reflect registered state only. An issue in cycle N is visible in cycle N+1.

## Configuration
- Macro: REGFILE_WB_ARB_STARVE_EN.
- Defined: the starvation counter and a_stall are built as described above.
- Undefined: wait_cnt is not built and a_stall is tied to 0. Priority is strictly A over the FIFO, so B may starve indefinitely.

## Test plan
- Reset, then check b_ready=0 and rf_we=0 during reset and b_ready=1 on the cycle after release. Then send B transfer rd=5, data=0xA5A5A5A5 with a_valid=0 → next cycle rf_we=1, rf_rd=5, rf_wd=0xA5A5A5A5.
- Collision: A (rd=3, 0x11) held every cycle while B enqueues rd=7 (0x22) → A is written every cycle while the FIFO holds rd=7. With the guard on, a_stall pulses once at the 8th wait cycle, and during that pulse rf_rd=7, rf_wd=0x22. With the macro undefined, rd=7 is never written while A is held.
- Fill: 4 B pushes with a_valid held → b_ready=0 after the 4th. A 5th b_valid is not accepted. Releasing A drains rd entries in FIFO order over 4 cycles.
- Scoreboard: issue rd=9, then rs1=9 → rs1_pending=1 on the next cycle. A B write to rd=9 reaches the port → rs1_pending=0 on the following cycle. An issue to rd=9 in the same cycle as the clear leaves pending=1.
- x0: a_valid with a_rd=0, B with rd=0, and issue with rd=0 → rf_we stays 0, the FIFO stays empty, and pending[0] stays 0.
- Reset mid-operation: 3 entries buffered and pending bits 4 and 6 set, then assert reset → FIFO empty, all pending 0, a_stall=0.
